flow_checker_64: RTL
====================

Name: flow_checker_64

Overview:
- Receive-side monitor for the 64-bit AXI-Stream output of the packet generator (or of a loopback path carrying it).
- Parses the Ethernet header of each frame and classifies the frame to a flow by source MAC.
- Checks frame length and payload fill byte against that flow's configuration; keeps per-flow packet, byte and error counters.
- Never back-pressures the stream, since the generator path has no tready.

Parameters:
- N_FLOWS, 4, number of flows; flow i uses slice [i*W +: W] of each list below.
- SIZES, {4{11'd192}}, expected frame length in bytes per flow (header plus payload, no FCS).
- D_MACS, {48'hABCDEF000001, ...000002, ...000003, ...000004}, expected destination MAC per flow.
- S_MACS, {48'hBEEFBEEF0001, ...0002, ...0003, ...0004}, source MAC per flow; used as the flow key.
- ETHERTYPES, {4{16'h0800}}, expected ethertype per flow.
- PAYLOADS, {8'hAA, 8'hBB, 8'hCC, 8'hDD}, expected payload fill byte per flow.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- clear, in, 1, synchronous clear of all counters.
- s_axis_tdata, in, 64, stream data; byte k in [8k+7:8k], byte 0 first on the wire.
- s_axis_tkeep, in, 8, byte enables; contiguous from bit 0.
- s_axis_tvalid, in, 1, beat valid.
- s_axis_tlast, in, 1, last beat of frame.
- pkt_count, out, N_FLOWS*32, good-frame count per flow; wraps.
- byte_count, out, N_FLOWS*48, bytes of good frames per flow; wraps.
- err_count, out, N_FLOWS*16, bad frames per flow; saturates at 16'hFFFF.
- unknown_count, out, 16, frames whose source MAC matches no flow; saturates.
- runt_count, out, 16, frames shorter than 14 bytes; saturates.
- frame_done, out, 1, one-cycle pulse per completed frame.
- frame_ok, out, 1, result of the last frame; valid while frame_done is high.
- frame_flow, out, $clog2(N_FLOWS) (min 1), flow index of the last frame.

Behaviour:
- Reset: all counters, frame_done, frame_ok and frame_flow are 0; FSM goes to HDR0.
- The block is always ready. A beat is accepted only when tvalid=1. Cycles with tvalid=0 hold all state, including mid-frame.
- Header byte order is MSB first: dst = bytes 0..5, src = bytes 6..11, ethertype = {byte12, byte13}, payload from byte 14.
- FSM:
  - HDR0: capture the dst MAC and src bytes 6-7. On tlast: runt; go to DONE. Otherwise go to HDR1.
  - HDR1: capture src bytes 8-11 and the ethertype. Compare src against all S_MACS in parallel; lowest matching index wins. Check bytes 14-15 where kept.
    - tlast with fewer than 14 bytes total: runt.
    - tlast otherwise: go to DONE.
    - no tlast: go to PAYLOAD.
  - PAYLOAD: compare every kept byte with PAYLOADS[flow]; any mismatch sets a sticky err flag. On tlast go to DONE.
  - DONE: lasts one cycle; accepts no beat and updates counters. Upstream must leave at least one idle cycle between frames; the generator's 64-bit FIFO output guarantees this. A beat arriving in DONE is ignored.
- Length: a running 11-bit sum of popcount(tkeep). It saturates at 2047, and any frame longer than 2047 bytes is a length error.
- Frame bad when any of these hold: dst != D_MACS[f], ethertype != ETHERTYPES[f], length != SIZES[f], or a payload mismatch.
- Counter update, registered on the DONE cycle:
  - runt: runt_count +1.
  - else no match: unknown_count +1.
  - else good: pkt_count[f] +1 and byte_count[f] + length.
  - else bad: err_count[f] +1.
- frame_done pulses for one cycle, registered at DONE. frame_ok = 1 only for a good matched frame. frame_flow = matched index, or 0 when there is no match.
- clear zeroes all counters on the next edge. It wins over a simultaneous DONE update; that frame is lost, but frame_done still pulses. clear does not affect the FSM.
- Reset asserted mid-frame: the partial frame is discarded and not counted. The next accepted beat is treated as HDR0.

Test Plan:
- Flow 0 frame: src BEEFBEEF0004, dst ABCDEF000004, type 0800, 178 bytes of DD, 24 full beats -> frame_done pulse, frame_ok=1, pkt_count[0]=1, byte_count[0]=192.
- Flow 2 frame (src BEEFBEEF0002, fill BB) with one payload byte = 00 in beat 10 -> err_count[2]=1, frame_ok=0, frame_flow=2, pkt_count unchanged.
- Flow 1 frame, 190 bytes (last tkeep=8'h3F), otherwise correct -> err_count[1]=1; byte_count[1] unchanged.
- Src BEEFBEEF0009 -> unknown_count=1. 8-byte frame (tlast on beat 0) -> runt_count=1. Neither touches the flow counters.
- 1000 back-to-back good flow-3 frames, each with one idle cycle, and tvalid randomly deasserted mid-frame -> pkt_count[3]=1000, byte_count[3]=192000.
- clear coincident with a good frame's DONE cycle -> all counters 0 afterwards; frame_done still pulses. rst mid-frame, then one good frame -> count 1.

Source files
------------

// File: rtl/flow_checker_64.sv
// Receive-side monitor for 64-bit AXI-Stream Ethernet frames: classifies each frame
// to a flow by source MAC, validates header/length/fill and keeps per-flow counters.
//
// state   | meaning
// HDR0    | first beat: dst MAC and src bytes 6-7
// HDR1    | second beat: src bytes 8-11, ethertype, flow lookup
// PAYLOAD | fill-byte checking until tlast
// DONE    | one cycle, counters update, no beat accepted
module flow_checker_64 #(
    parameter int                    N_FLOWS    = 4,
    parameter logic [N_FLOWS*11-1:0] SIZES      = {4{11'd192}},
    parameter logic [N_FLOWS*48-1:0] D_MACS     = {48'hABCDEF000001, 48'hABCDEF000002,
                                                   48'hABCDEF000003, 48'hABCDEF000004},
    parameter logic [N_FLOWS*48-1:0] S_MACS     = {48'hBEEFBEEF0001, 48'hBEEFBEEF0002,
                                                   48'hBEEFBEEF0003, 48'hBEEFBEEF0004},
    parameter logic [N_FLOWS*16-1:0] ETHERTYPES = {4{16'h0800}},
    parameter logic [N_FLOWS*8-1:0]  PAYLOADS   = {8'hAA, 8'hBB, 8'hCC, 8'hDD},
    localparam int                   FW         = (N_FLOWS > 1) ? $clog2(N_FLOWS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic [63:0]             s_axis_tdata,
    input  logic [7:0]              s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic [N_FLOWS*32-1:0]   pkt_count,
    output logic [N_FLOWS*48-1:0]   byte_count,
    output logic [N_FLOWS*16-1:0]   err_count,
    output logic [15:0]             unknown_count,
    output logic [15:0]             runt_count,
    output logic                    frame_done,
    output logic                    frame_ok,
    output logic [FW-1:0]           frame_flow
);

    typedef enum logic [1:0] {HDR0, HDR1, PAYLOAD, DONE} state_t;

    state_t          r_state;
    state_t          w_next;

    logic [47:0]     r_dst;
    logic [15:0]     r_src_hi;
    logic [15:0]     r_etype;
    logic [10:0]     r_len;
    logic            r_len_ovf;
    logic            r_perr;
    logic            r_runt;
    logic            r_match;
    logic [FW-1:0]   r_flow;

    logic [31:0]     r_pkt  [N_FLOWS];
    logic [47:0]     r_byte [N_FLOWS];
    logic [15:0]     r_err  [N_FLOWS];
    logic [15:0]     r_unknown;
    logic [15:0]     r_runt_cnt;
    logic            r_frame_done;
    logic            r_frame_ok;
    logic [FW-1:0]   r_frame_flow;

    logic            w_accept;
    logic [3:0]      w_beat_bytes;
    logic [11:0]     w_len_sum;
    logic [10:0]     w_len_next;
    logic            w_ovf_next;
    logic [47:0]     w_src;
    logic [15:0]     w_etype;
    logic            w_match;
    logic [FW-1:0]   w_flow_hit;
    logic [FW-1:0]   w_cmp_flow;
    logic [7:0]      w_exp_byte;
    logic            w_pay_bad;
    logic [47:0]     w_exp_dst;
    logic [15:0]     w_exp_etype;
    logic [10:0]     w_exp_size;
    logic            w_good;

    assign w_accept = s_axis_tvalid && (r_state != DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= HDR0;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            HDR0:    if (w_accept) w_next = s_axis_tlast ? DONE : HDR1;
            HDR1:    if (w_accept) w_next = s_axis_tlast ? DONE : PAYLOAD;
            PAYLOAD: if (w_accept && s_axis_tlast) w_next = DONE;
            default: w_next = HDR0;
        endcase
    end

    always_comb begin
        w_beat_bytes = 4'd0;
        for (int k = 0; k < 8; k++) w_beat_bytes = w_beat_bytes + {3'd0, s_axis_tkeep[k]};
    end

    assign w_len_sum  = ((r_state == HDR0) ? 12'd0 : {1'b0, r_len}) + {8'd0, w_beat_bytes};
    assign w_len_next = w_len_sum[11] ? 11'h7FF : w_len_sum[10:0];
    assign w_ovf_next = ((r_state == HDR0) ? 1'b0 : r_len_ovf) | w_len_sum[11];

    assign w_src   = {r_src_hi, s_axis_tdata[7:0], s_axis_tdata[15:8],
                      s_axis_tdata[23:16], s_axis_tdata[31:24]};
    assign w_etype = {s_axis_tdata[39:32], s_axis_tdata[47:40]};

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        w_match    = 1'b0;
        w_flow_hit = '0;
        for (int i = N_FLOWS - 1; i >= 0; i--) begin
            if (w_src == S_MACS[i*48 +: 48]) begin
                w_match    = 1'b1;
                w_flow_hit = FW'(i);
            end
        end
    end

    assign w_cmp_flow = (r_state == HDR1) ? w_flow_hit : r_flow;

    always_comb begin
        w_exp_byte  = '0;
        w_exp_dst   = '0;
        w_exp_etype = '0;
        w_exp_size  = '0;
        for (int i = 0; i < N_FLOWS; i++) begin
            if (w_cmp_flow == FW'(i)) w_exp_byte = PAYLOADS[i*8 +: 8];
            if (r_flow == FW'(i)) begin
                w_exp_dst   = D_MACS[i*48 +: 48];
                w_exp_etype = ETHERTYPES[i*16 +: 16];
                w_exp_size  = SIZES[i*11 +: 11];
            end
        end
    end

    // In HDR1 only bytes 14-15 (lanes 6-7) are payload.
    always_comb begin
        w_pay_bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (s_axis_tkeep[k] && ((r_state == PAYLOAD) || ((r_state == HDR1) && (k >= 6))) &&
                (s_axis_tdata[8*k +: 8] != w_exp_byte))
                w_pay_bad = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dst     <= '0;
            r_src_hi  <= '0;
            r_etype   <= '0;
            r_len     <= '0;
            r_len_ovf <= 1'b0;
            r_perr    <= 1'b0;
            r_runt    <= 1'b0;
            r_match   <= 1'b0;
            r_flow    <= '0;
        end else if (w_accept) begin
            r_len     <= w_len_next;
            r_len_ovf <= w_ovf_next;
            case (r_state)
                HDR0: begin
                    r_dst    <= {s_axis_tdata[7:0], s_axis_tdata[15:8], s_axis_tdata[23:16],
                                 s_axis_tdata[31:24], s_axis_tdata[39:32], s_axis_tdata[47:40]};
                    r_src_hi <= {s_axis_tdata[55:48], s_axis_tdata[63:56]};
                    r_perr   <= 1'b0;
                    r_runt   <= s_axis_tlast;
                    r_match  <= 1'b0;
                    r_flow   <= '0;
                end
                HDR1: begin
                    r_etype <= w_etype;
                    r_match <= w_match;
                    r_flow  <= w_flow_hit;
                    r_perr  <= w_pay_bad;
                    r_runt  <= s_axis_tlast && (w_len_sum < 12'd14);
                end
                default: r_perr <= r_perr | w_pay_bad;
            endcase
        end
    end

    assign w_good = r_match && !r_runt && !r_perr && !r_len_ovf && (r_len == w_exp_size) &&
                    (r_dst == w_exp_dst) && (r_etype == w_exp_etype);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_FLOWS; i++) begin
                r_pkt[i]  <= '0;
                r_byte[i] <= '0;
                r_err[i]  <= '0;
            end
            r_unknown    <= '0;
            r_runt_cnt   <= '0;
            r_frame_done <= 1'b0;
            r_frame_ok   <= 1'b0;
            r_frame_flow <= '0;
        end else begin
            r_frame_done <= (r_state == DONE);
            if (r_state == DONE) begin
                r_frame_ok   <= w_good;
                r_frame_flow <= r_match ? r_flow : '0;
            end
            // clear wins over the DONE update; that frame is dropped from the counters.
            if (clear) begin
                for (int i = 0; i < N_FLOWS; i++) begin
                    r_pkt[i]  <= '0;
                    r_byte[i] <= '0;
                    r_err[i]  <= '0;
                end
                r_unknown  <= '0;
                r_runt_cnt <= '0;
            end else if (r_state == DONE) begin
                if (r_runt) begin
                    if (r_runt_cnt != 16'hFFFF) r_runt_cnt <= r_runt_cnt + 16'd1;
                end else if (!r_match) begin
                    if (r_unknown != 16'hFFFF) r_unknown <= r_unknown + 16'd1;
                end else if (w_good) begin
                    r_pkt[r_flow]  <= r_pkt[r_flow] + 32'd1;
                    r_byte[r_flow] <= r_byte[r_flow] + {37'd0, r_len};
                end else if (r_err[r_flow] != 16'hFFFF) begin
                    r_err[r_flow] <= r_err[r_flow] + 16'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < N_FLOWS; g++) begin : g_out
        assign pkt_count[g*32 +: 32]  = r_pkt[g];
        assign byte_count[g*48 +: 48] = r_byte[g];
        assign err_count[g*16 +: 16]  = r_err[g];
    end

    assign unknown_count = r_unknown;
    assign runt_count    = r_runt_cnt;
    assign frame_done    = r_frame_done;
    assign frame_ok      = r_frame_ok;
    assign frame_flow    = r_frame_flow;

endmodule
